// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared types, op encoding and op-class helpers for the RV32M multiply/divide unit
package ex_muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      MULDIV_MUL    = 3'd0,
      MULDIV_MULH   = 3'd1,
      MULDIV_MULHSU = 3'd2,
      MULDIV_MULHU  = 3'd3,
      MULDIV_DIV    = 3'd4,
      MULDIV_DIVU   = 3'd5,
      MULDIV_REM    = 3'd6,
      MULDIV_REMU   = 3'd7
   } MulDivOp;

   typedef struct packed {
      logic flush;
      logic stall;
   } PipeControl;

   typedef struct packed {
      logic stall_req;
      logic flush_req;
   } PipeRequest;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   function automatic logic op_is_div(input MulDivOp op);
      return op[2];
   endfunction

   function automatic logic op_is_rem(input MulDivOp op);
      return op[2] & op[1];
   endfunction

   // MUL itself is treated as unsigned: its low half does not depend on operand signs.
   function automatic logic op_signed_a(input MulDivOp op);
      return (op == MULDIV_MULH) || (op == MULDIV_MULHSU) || (op == MULDIV_DIV) || (op == MULDIV_REM);
   endfunction

   function automatic logic op_signed_b(input MulDivOp op);
      return (op == MULDIV_MULH) || (op == MULDIV_DIV) || (op == MULDIV_REM);
   endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - operand/result bundle between the EX stage and the multiply/divide unit
interface ex_muldiv_if
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) ();

   logic            start;
   MulDivOp         op;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] result;
   logic            done;

   modport master (
      output start, op, rs1_data, rs2_data,
      input  result, done
   );

   modport slave (
      input  start, op, rs1_data, rs2_data,
      output result, done
   );

endinterface

// File: rtl/ex_muldiv_iter_core.sv
// rtl/ex_muldiv_iter_core.sv - unsigned shift-add multiply / restoring divide datapath, one step per cycle
// hi/lo present the accumulators as they will be after the current step, so the final step can be captured directly.
module muldiv_iter_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic            is_div,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   logic [XLEN-1:0] a_q, b_q, hi_q, lo_q;
   logic            div_q;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   rem_shift;
   logic [XLEN:0]   rem_diff;
   logic            rem_ge;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
      rem_shift = {hi_q, lo_q[XLEN-1]};
      rem_diff  = rem_shift - {1'b0, b_q};
      // The partial remainder stays below the divisor, so the borrow bit alone decides.
      rem_ge    = ~rem_diff[XLEN];
      if (div_q) begin
         hi = rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
         lo = {lo_q[XLEN-2:0], rem_ge};
      end else begin
         hi = mul_sum[XLEN:1];
         lo = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         div_q <= 1'b0;
      end else if (load) begin
         a_q   <= a;
         b_q   <= b;
         hi_q  <= '0;
         lo_q  <= is_div ? a : b;
         div_q <= is_div;
      end else if (step) begin
         hi_q  <= hi;
         lo_q  <= lo;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide EX unit: FSM, special cases, sign fix, stall request
// MULDIV_FAST_MUL_EN selects a single-cycle multiplier for the MUL* ops; divide always iterates.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   ex_muldiv_if.slave bus,
   input  PipeControl id_ex_ctrl,
   input  PipeControl ex_ma_ctrl,
   output PipeRequest muldiv_req
);

   localparam int              CNT_W    = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e   state, state_nxt;
   logic [CNT_W-1:0] cnt;
   MulDivOp         op_q;
   logic            sa_q, sb_q;
   logic [XLEN-1:0] result_q;

   logic            flush, accept, load, step, finish, stall_req;
   logic            sgn_a, sgn_b;
   logic [XLEN-1:0] abs_a, abs_b;
   logic            div_zero, div_ovf, special, fast_mul;
   logic [XLEN-1:0] special_res, fast_res, iter_res;
   logic [XLEN-1:0] core_hi, core_lo;
   logic            unused_ctrl;

   assign flush       = id_ex_ctrl.flush;
   assign unused_ctrl = id_ex_ctrl.stall ^ ex_ma_ctrl.flush;
   assign accept      = (state == ST_IDLE) && bus.start && !flush;

   assign sgn_a = op_signed_a(bus.op) && bus.rs1_data[XLEN-1];
   assign sgn_b = op_signed_b(bus.op) && bus.rs2_data[XLEN-1];
   assign abs_a = sgn_a ? -bus.rs1_data : bus.rs1_data;
   assign abs_b = sgn_b ? -bus.rs2_data : bus.rs2_data;

   assign div_zero = op_is_div(bus.op) && (bus.rs2_data == '0);
   assign div_ovf  = ((bus.op == MULDIV_DIV) || (bus.op == MULDIV_REM)) &&
                     (bus.rs1_data == INT_MIN) && (bus.rs2_data == '1);
   assign special  = div_zero || div_ovf;

   always_comb begin
      special_res = '1;
      if (div_zero) begin
         special_res = op_is_rem(bus.op) ? bus.rs1_data : '1;
      end else begin
         special_res = op_is_rem(bus.op) ? '0 : INT_MIN;
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

   // Sign-extended operands make the low 2*XLEN bits of an unsigned product correct for every MUL* variant.
   assign fast_a    = {{XLEN{sgn_a}}, bus.rs1_data};
   assign fast_b    = {{XLEN{sgn_b}}, bus.rs2_data};
   assign fast_prod = fast_a * fast_b;
   assign fast_mul  = !op_is_div(bus.op);
   assign fast_res  = (bus.op == MULDIV_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
   assign fast_mul  = 1'b0;
   assign fast_res  = '0;
`endif

   assign finish = (state == ST_BUSY) && (cnt == CNT_LAST) && !flush;

   always_comb begin
      state_nxt = state;
      stall_req = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         ST_IDLE: begin
            stall_req = bus.start;
            if (bus.start) begin
               if (special || fast_mul) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_BUSY;
                  load      = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            stall_req = 1'b1;
            step      = 1'b1;
            if (cnt == CNT_LAST) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (!ex_ma_ctrl.stall) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (flush) begin
         state_nxt = ST_IDLE;
         stall_req = 1'b0;
         load      = 1'b0;
         step      = 1'b0;
      end
   end

   // Negating a 2*XLEN product only needs its high half: carry from the low half exists only when it is zero.
   always_comb begin
      iter_res = core_lo;
      case (op_q)
         MULDIV_MUL:
            iter_res = core_lo;
         MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU:
            iter_res = (sa_q ^ sb_q) ? (~core_hi + XLEN'(core_lo == '0)) : core_hi;
         MULDIV_DIV, MULDIV_DIVU:
            iter_res = (sa_q ^ sb_q) ? -core_lo : core_lo;
         default:
            iter_res = sa_q ? -core_hi : core_hi;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         op_q     <= MULDIV_MUL;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         result_q <= '0;
      end else begin
         if (load) begin
            cnt <= '0;
         end else if (step) begin
            cnt <= cnt + 1'b1;
         end
         if (accept) begin
            op_q <= bus.op;
            sa_q <= sgn_a;
            sb_q <= sgn_b;
         end
         if (accept && (special || fast_mul)) begin
            result_q <= special ? special_res : fast_res;
         end else if (finish) begin
            result_q <= iter_res;
         end
      end
   end

   muldiv_iter_core #(
      .XLEN (XLEN)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .step   (step),
      .is_div (op_is_div(bus.op)),
      .a      (abs_a),
      .b      (abs_b),
      .hi     (core_hi),
      .lo     (core_lo)
   );

   assign bus.result           = result_q;
   assign bus.done             = (state == ST_DONE) && !flush;
   assign muldiv_req.stall_req = stall_req;
   assign muldiv_req.flush_req = 1'b0;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv: vector table, corner sequences, random ops vs arithmetic model
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic       clk;
   logic       rst_n;
   PipeControl id_ex_ctrl;
   PipeControl ex_ma_ctrl;
   PipeRequest muldiv_req;
   int         total;
   int         bad;

   ex_muldiv_if bus ();

   ex_muldiv dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .id_ex_ctrl (id_ex_ctrl),
      .ex_ma_ctrl (ex_ma_ctrl),
      .muldiv_req (muldiv_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      MulDivOp    op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, exp);
      end
   endfunction

   // RV32M semantics computed with 64-bit signed arithmetic.
   function automatic logic [31:0] ref_model(input MulDivOp o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'h0, a};
      ub = {32'h0, b};
      p  = 0;
      case (o)
         MULDIV_MUL:    p = sa * sb;
         MULDIV_MULH:   p = (sa * sb) >>> 32;
         MULDIV_MULHSU: p = (sa * ub) >>> 32;
         MULDIV_MULHU:  p = (ua * ub) >> 32;
         MULDIV_DIV:    p = (b == 0) ? -1 : sa / sb;
         MULDIV_DIVU:   p = (b == 0) ? -1 : ua / ub;
         MULDIV_REM:    p = (b == 0) ? sa : sa % sb;
         default:       p = (b == 0) ? ua : ua % ub;
      endcase
      return p[31:0];
   endfunction

   function automatic int exp_stalls(input MulDivOp o, input logic [31:0] a, input logic [31:0] b);
      if (o[2] && b == 32'h0) return 1;
      if ((o == MULDIV_DIV || o == MULDIV_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!o[2]) return 1;
`endif
      return 33;
   endfunction

   // Called at a falling edge; returns at a falling edge with the unit back in IDLE and start low.
   task automatic run_op(input string name, input MulDivOp o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold);
      int stalls;
      logic got_done;
      stalls   = 0;
      got_done = 1'b0;
      bus.op       = o;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.start    = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (i == 1) begin
            bus.op       = MulDivOp'($urandom_range(7));
            bus.rs1_data = $urandom;
            bus.rs2_data = $urandom;
         end
         #1;
         if (bus.done) begin
            got_done = 1'b1;
            break;
         end
         if (muldiv_req.stall_req) stalls++;
         @(negedge clk);
      end
      check({name, "_done"}, 32'(got_done), 32'd1);
      check({name, "_stalls"}, stalls, exp_stalls(o, a, b));
      check({name, "_result"}, bus.result, exp);
      ex_ma_ctrl.stall = (hold > 0);
      for (int h = 1; h < hold; h++) begin
         @(negedge clk);
         #1;
         check({name, "_held_done"}, 32'(bus.done), 32'd1);
         check({name, "_held_result"}, bus.result, exp);
      end
      ex_ma_ctrl.stall = 1'b0;
      bus.start        = 1'b0;
      @(negedge clk);
      if (hold > 0) begin
         #1;
         check({name, "_after_hold_done"}, 32'(bus.done), 32'd0);
         @(negedge clk);
      end
   endtask

   vec_t vecs[$];

   initial begin
      int done_pulses;
      MulDivOp ro;
      logic [31:0] ra, rb;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      id_ex_ctrl   = '0;
      ex_ma_ctrl   = '0;
      bus.start    = 1'b0;
      bus.op       = MULDIV_MUL;
      bus.rs1_data = '0;
      bus.rs2_data = '0;

      vecs.push_back('{"mul_7_m3",     MULDIV_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
      vecs.push_back('{"mul_6_7",      MULDIV_MUL,    32'd6,          32'd7,         32'd42});
      vecs.push_back('{"mulhu_max",    MULDIV_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
      vecs.push_back('{"mulhsu_m1_2",  MULDIV_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF});
      vecs.push_back('{"mulh_min_min", MULDIV_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
      vecs.push_back('{"div_m7_2",     MULDIV_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
      vecs.push_back('{"rem_m7_2",     MULDIV_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
      vecs.push_back('{"divu_100_7",   MULDIV_DIVU,   32'd100,        32'd7,         32'd14});
      vecs.push_back('{"remu_100_7",   MULDIV_REMU,   32'd100,        32'd7,         32'd2});
      vecs.push_back('{"div_by0",      MULDIV_DIV,    32'h0000_1234,  32'd0,         32'hFFFF_FFFF});
      vecs.push_back('{"rem_5_by0",    MULDIV_REM,    32'd5,          32'd0,         32'd5});
      vecs.push_back('{"divu_by0",     MULDIV_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF});
      vecs.push_back('{"remu_9_by0",   MULDIV_REMU,   32'd9,          32'd0,         32'd9});
      vecs.push_back('{"div_ovf",      MULDIV_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
      vecs.push_back('{"rem_ovf",      MULDIV_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
      vecs.push_back('{"divu_min_m1",  MULDIV_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0});

      repeat (2) @(negedge clk);
      #1;
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_result", bus.result, 32'd0);
      check("reset_stall", 32'(muldiv_req.stall_req), 32'd0);
      check("reset_flush_req", 32'(muldiv_req.flush_req), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);
      end

      run_op("hold3", MULDIV_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 3);

      bus.op = MULDIV_MUL; bus.rs1_data = 32'd3; bus.rs2_data = 32'd4;
      bus.start = 1'b1; id_ex_ctrl.flush = 1'b1;
      #1;
      check("flush_beats_start_stall", 32'(muldiv_req.stall_req), 32'd0);
      @(negedge clk);
      bus.start = 1'b0; id_ex_ctrl.flush = 1'b0;
      #1;
      check("flush_beats_start_idle", 32'(muldiv_req.stall_req), 32'd0);
      @(negedge clk);

      bus.op = MULDIV_DIV; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd7; bus.start = 1'b1;
      #1;
      check("flush_seq_first_stall", 32'(muldiv_req.stall_req), 32'd1);
      repeat (10) @(negedge clk);
      id_ex_ctrl.flush = 1'b1; bus.start = 1'b0;
      #1;
      check("flush_busy_stall", 32'(muldiv_req.stall_req), 32'd0);
      check("flush_busy_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      id_ex_ctrl.flush = 1'b0;
      #1;
      check("after_flush_stall", 32'(muldiv_req.stall_req), 32'd0);
      done_pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (bus.done) done_pulses++;
      end
      check("after_flush_done_pulses", done_pulses, 0);
      @(negedge clk);
      run_op("divu_9_3_after_flush", MULDIV_DIVU, 32'd9, 32'd3, 32'd3, 0);

      bus.op = MULDIV_DIVU; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd3; bus.start = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0; bus.start = 1'b0;
      #1;
      check("midbusy_reset_stall", 32'(muldiv_req.stall_req), 32'd0);
      check("midbusy_reset_done", 32'(bus.done), 32'd0);
      check("midbusy_reset_result", bus.result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("post_reset_stall", 32'(muldiv_req.stall_req), 32'd0);
      @(negedge clk);

      for (int i = 0; i < 30; i++) begin
         ro = MulDivOp'($urandom_range(7));
         ra = $urandom;
         case ($urandom_range(9))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = $urandom_range(1, 15);
            default: rb = $urandom;
         endcase
         if ($urandom_range(5) == 0) ra = 32'h8000_0000;
         run_op($sformatf("rand%0d", i), ro, ra, rb, ref_model(ro, ra, rb), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
